// File: rtl/riscv_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_fetch_pkg
// Description : Shared types and defaults for the instruction fetch stage.
//               Holds the fetch FSM state encoding and the fetch-queue entry
//               layout (instruction word plus the PC it was fetched from).
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_fetch_pkg;

    localparam int          XLEN        = 32;
    localparam int          INSTR_WIDTH = 32;
    localparam logic [31:0] RESET_PC    = 32'h0000_0000;

    // Explicit one-bit encoding: IDLE must be the reset value.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [XLEN-1:0]        pc;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_unit_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Synchronous FIFO of fetch entries between instruction memory
//               and decode. Flush empties the queue and has priority over
//               push and pop. Push is ignored when full, pop when empty.
// Ports       : clk, rst         - clock / synchronous active-high reset
//               flush            - discard all entries, reset pointers
//               push, push_data  - write an entry at the tail
//               pop              - advance the head
//               full, empty      - occupancy flags
//               head             - entry at the head (valid when !empty)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import riscv_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign head      = r_mem[r_rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage needs no reset: reads are only meaningful when !empty.
    always_ff @(posedge clk) begin
        if (w_do_push && !flush && !rst) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : Fetch-stage initiator. Owns the PC, drives instruction memory
//               address/read-enable, queues returned instructions with their
//               PC and hands them to decode over valid/ready. Redirects flush
//               the queue and reload the PC.
// Ports       : clk, rst                    - clock / sync active-high reset
//               fetch_en                    - permit new fetches
//               redirect_valid, redirect_pc - PC redirect (highest priority)
//               imem_addr, imem_read_en     - memory request
//               imem_instruction            - combinational memory data
//               out_valid, out_ready        - decode handshake
//               out_instr, out_pc           - head instruction and its PC
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit
    import riscv_fetch_pkg::fetch_entry_t;
    import riscv_fetch_pkg::fetch_state_e;
    import riscv_fetch_pkg::IDLE;
    import riscv_fetch_pkg::RUN;
#(
    parameter int              XLEN         = 32,
    parameter int              WIDTH        = 32,
    parameter int              ADDRESS_SIZE = 10,
    parameter int              FQ_DEPTH     = 2,
    parameter logic [XLEN-1:0] RESET_PC     = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fetch_en,
    input  logic                    redirect_valid,
    input  logic [XLEN-1:0]         redirect_pc,
    output logic [ADDRESS_SIZE-1:0] imem_addr,
    output logic                    imem_read_en,
    input  logic [WIDTH-1:0]        imem_instruction,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_instr,
    output logic [XLEN-1:0]         out_pc
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    logic [XLEN-1:0] r_pc;

    logic            w_fetch;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_entry;

    // ------------------------------------------------------------------
    // FSM: leaves IDLE on the first fetch_en or redirect; never returns
    // except through reset. Fetching is only allowed in RUN.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fetch     = 1'b0;
        case (r_state)
            IDLE: begin
                if (fetch_en || redirect_valid) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                // Full blocks the push even when a pop frees a slot this
                // cycle, so out_ready never reaches imem_read_en.
                w_fetch = fetch_en & ~redirect_valid & ~w_full & ~rst;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Program counter (wraps modulo 2^XLEN)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        end else if (w_fetch) begin
            r_pc <= r_pc + XLEN'(4);
        end
    end

    assign imem_addr    = r_pc[ADDRESS_SIZE+1:2];
    assign imem_read_en = w_fetch;

    // ------------------------------------------------------------------
    // Fetch queue; a redirect flush also discards any same-cycle pop.
    // ------------------------------------------------------------------
    assign w_push_entry.instr = imem_instruction;
    assign w_push_entry.pc    = r_pc;
    assign w_pop              = ~w_empty & out_ready;

    fetch_queue #(
        .DEPTH     (FQ_DEPTH)
    ) u_fetch_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (w_fetch),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .head      (w_head)
    );

    assign out_valid = ~w_empty;
    assign out_instr = w_empty ? '0 : w_head.instr;
    assign out_pc    = w_empty ? '0 : w_head.pc;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Directed self-checking bench for instruction_fetch_unit with
//               a combinational instruction-memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;
    import riscv_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [9:0]  imem_addr;
    logic        imem_read_en;
    logic [31:0] imem_instruction;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int tests = 0;
    int fails = 0;

    instruction_fetch_unit #(
        .XLEN             (32),
        .WIDTH            (32),
        .ADDRESS_SIZE     (10),
        .FQ_DEPTH         (2),
        .RESET_PC         (32'h0000_0000)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_en         (fetch_en),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .imem_addr        (imem_addr),
        .imem_read_en     (imem_read_en),
        .imem_instruction (imem_instruction),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_instr        (out_instr),
        .out_pc           (out_pc)
    );

    always #5 clk = ~clk;

    // Memory words 0..3 hold the program; every other word is C000_0000|addr.
    function automatic logic [31:0] mem_word(input logic [9:0] a);
        case (a)
            10'd0:   mem_word = 32'h0000_0013;
            10'd1:   mem_word = 32'h0010_0093;
            10'd2:   mem_word = 32'h0020_0113;
            10'd3:   mem_word = 32'h0030_0193;
            default: mem_word = 32'hC000_0000 | {22'h0, a};
        endcase
    endfunction

    assign imem_instruction = mem_word(imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs set afterwards
    // apply to the new cycle, checks follow a further #1.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset ----------------
        tick(); tick();
        #1;
        check("rst_valid",   32'(out_valid),    32'd0);
        check("rst_rden",    32'(imem_read_en), 32'd0);
        check("rst_addr",    32'(imem_addr),    32'd0);
        check("rst_pc",      out_pc,            32'd0);
        check("rst_instr",   out_instr,         32'd0);

        // ---------------- streaming, cycle 0 is IDLE ----------------
        tick();
        rst = 1'b0; fetch_en = 1'b1; out_ready = 1'b1; #1;
        check("idle_rden",   32'(imem_read_en), 32'd0);
        tick(); #1;                                       // cycle 1
        check("c1_rden",     32'(imem_read_en), 32'd1);
        check("c1_valid",    32'(out_valid),    32'd0);
        tick(); #1;                                       // cycle 2
        check("c2_valid",    32'(out_valid),    32'd1);
        check("c2_pc",       out_pc,            32'h0);
        check("c2_instr",    out_instr,         32'h0000_0013);
        tick(); #1;
        check("c3_pc",       out_pc,            32'h4);
        check("c3_instr",    out_instr,         32'h0010_0093);
        tick(); #1;
        check("c4_pc",       out_pc,            32'h8);
        check("c4_instr",    out_instr,         32'h0020_0113);
        tick(); #1;
        check("c5_pc",       out_pc,            32'hC);
        check("c5_instr",    out_instr,         32'h0030_0193);

        // ---------------- back-pressure from reset ----------------
        tick(); rst = 1'b1;
        tick(); rst = 1'b0; fetch_en = 1'b1; out_ready = 1'b0; // cycle 0
        tick();                                                // cycle 1
        tick(); #1;                                            // cycle 2
        check("bp2_rden",    32'(imem_read_en), 32'd1);
        check("bp2_addr",    32'(imem_addr),    32'd1);
        tick(); #1;                                            // cycle 3
        check("bp3_rden",    32'(imem_read_en), 32'd0);
        check("bp3_addr",    32'(imem_addr),    32'd2);
        check("bp3_pc",      out_pc,            32'h0);
        tick(); #1;
        check("bp4_rden",    32'(imem_read_en), 32'd0);
        check("bp4_addr",    32'(imem_addr),    32'd2);
        tick(); out_ready = 1'b1; #1;                          // cycle 5
        check("bp5_pc",      out_pc,            32'h0);
        check("bp5_rden",    32'(imem_read_en), 32'd0);
        tick(); #1;
        check("bp6_pc",      out_pc,            32'h4);
        check("bp6_rden",    32'(imem_read_en), 32'd1);
        tick(); out_ready = 1'b0; #1;                          // cycle 7
        check("bp7_pc",      out_pc,            32'h8);
        check("bp7_addr",    32'(imem_addr),    32'd3);

        // ---------------- redirect while full ----------------
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0023; out_ready = 1'b1; #1;
        check("rd_full_rden", 32'(imem_read_en), 32'd0);
        check("rd_full_pc",   out_pc,            32'h8);
        tick(); redirect_valid = 1'b0; #1;
        check("rd1_valid",   32'(out_valid),    32'd0);
        check("rd1_addr",    32'(imem_addr),    32'd8);
        check("rd1_rden",    32'(imem_read_en), 32'd1);
        tick(); #1;
        check("rd2_pc",      out_pc,            32'h20);
        check("rd2_instr",   out_instr,         32'hC000_0008);

        // ---------------- PC wrap ----------------
        tick(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
        check("rd3_pc",      out_pc,            32'h24);
        tick(); redirect_valid = 1'b0; #1;
        check("wr_addr0",    32'(imem_addr),    32'h3FF);
        check("wr_valid0",   32'(out_valid),    32'd0);
        tick(); #1;
        check("wr_pc1",      out_pc,            32'hFFFF_FFFC);
        check("wr_instr1",   out_instr,         32'hC000_03FF);
        check("wr_addr1",    32'(imem_addr),    32'h000);
        tick(); #1;
        check("wr_pc2",      out_pc,            32'h0);
        check("wr_instr2",   out_instr,         32'h0000_0013);

        // ---------------- reset beats redirect ----------------
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0100; #1;
        check("rr_rden",     32'(imem_read_en), 32'd0);
        tick(); rst = 1'b0; redirect_valid = 1'b0; fetch_en = 1'b1; #1;
        check("rr_valid",    32'(out_valid),    32'd0);
        check("rr_addr",     32'(imem_addr),    32'd0);
        check("rr_pcreg",    dut.r_pc,          32'h0);
        check("rr_state",    32'(dut.r_state),  32'(IDLE));
        check("rr_rden2",    32'(imem_read_en), 32'd0);

        // ---------------- fetch_en toggling ----------------
        tick(); fetch_en = 1'b1; #1;
        check("tg1_rden",    32'(imem_read_en), 32'd1);
        tick(); fetch_en = 1'b0; #1;
        check("tg2_valid",   32'(out_valid),    32'd1);
        check("tg2_pc",      out_pc,            32'h0);
        check("tg2_rden",    32'(imem_read_en), 32'd0);
        tick(); fetch_en = 1'b1; #1;
        check("tg3_valid",   32'(out_valid),    32'd0);
        check("tg3_addr",    32'(imem_addr),    32'd1);
        tick(); fetch_en = 1'b0; #1;
        check("tg4_pc",      out_pc,            32'h4);
        tick(); fetch_en = 1'b1; #1;
        check("tg5_valid",   32'(out_valid),    32'd0);
        check("tg5_addr",    32'(imem_addr),    32'd2);
        tick(); fetch_en = 1'b0; #1;
        check("tg6_pc",      out_pc,            32'h8);
        check("tg6_instr",   out_instr,         32'h0020_0113);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch-stage initiator for `instruction_memory`: owns the program counter, drives the memory's word address and read enable, captures each returned instruction with its PC into a small fetch queue, and presents it to decode through a valid/ready handshake. Accepts redirects (branch/jump/exception targets) from later stages, flushing queued wrong-path instructions. It sits between `instruction_memory` and the IF/ID boundary of the pipeline.

## Interface
- `XLEN`, 32, PC width in bits
- `WIDTH`, 32, instruction width; matches memory `WIDTH`
- `ADDRESS_SIZE`, 10, memory word-address width; matches memory `ADDRESS_SIZE`
- `FQ_DEPTH`, 2, fetch-queue entries; power of two, ≥2
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `clk`  input  1  clock, all state on rising edge
- `rst`  input  1  synchronous, active-high reset
- `fetch_en`  input  1  permits new fetches; 0 stalls PC, does not flush
- `redirect_valid`  input  1  redirect request, highest priority
- `redirect_pc`  input  XLEN  redirect target; bits [1:0] ignored (forced 0)
- `imem_addr`  output  ADDRESS_SIZE  word address = `pc[ADDRESS_SIZE+1:2]`
- `imem_read_en`  output  1  memory read enable
- `imem_instruction`  input  WIDTH  combinational memory read data
- `out_valid`  output  1  queue head holds a valid instruction
- `out_ready`  input  1  decode accepts head this cycle
- `out_instr`  output  WIDTH  head instruction
- `out_pc`  output  XLEN  head instruction's PC

## Operation
- Push condition `fetch = fetch_en & ~redirect_valid & ~full & ~rst`; `imem_read_en = fetch`, combinational.
- On `fetch`: `{imem_instruction, pc}` written to queue tail at the edge; `pc <= pc + 4`.
- Pop on `out_valid & out_ready`; head advances. Push and pop in the same cycle both take effect; count unchanged.
- Full blocks push even if a pop occurs that cycle (no ready→read_en path).
- `redirect_valid`: queue flushed (count=0, pointers reset), `pc <= {redirect_pc[XLEN-1:2],2'b00}`, no fetch that cycle; a simultaneous pop is discarded by the flush.
- PC arithmetic modulo 2^XLEN; wraps 0xFFFF_FFFC → 0. `imem_addr` truncates; PCs ≥ 4·2^ADDRESS_SIZE alias into memory.
- Two-state FSM: `IDLE` (after reset, `imem_read_en`=0) → `RUN` on first cycle with `fetch_en`=1 or `redirect_valid`=1; `RUN` never returns to `IDLE` except via `rst`. In `IDLE`, redirect updates PC only.
- `out_instr`/`out_pc` are don't-care when `out_valid`=0; driven zero by implementation.

## Timing
- Reset (sync, wins over all inputs): `pc`=RESET_PC, queue empty, state `IDLE`, `out_valid`=0, `out_instr`=0, `out_pc`=0, `imem_read_en`=0; `imem_addr` = RESET_PC word index.
- Fetch latency: PC presented in cycle N with `imem_read_en`=1 → `out_valid`=1 with that PC in cycle N+1.
- Redirect latency: `redirect_valid` in cycle N → `out_valid`=0 in N+1, target fetched in N+1, target visible at head in N+2.
- Sustained throughput: one instruction/cycle while `out_ready`=1 and `fetch_en`=1.
- Back-pressure: with `out_ready`=0, exactly FQ_DEPTH fetches complete, then `imem_read_en` drops and `pc` holds.
- Reset mid-operation discards queue contents and in-flight fetch.

## Structure
- Package `riscv_fetch_pkg`: `XLEN`, `INSTR_WIDTH`, `RESET_PC` default, `fetch_state_e` {IDLE, RUN}, `fetch_entry_t` struct {instr, pc}.
- Sub-module `fetch_queue`: synchronous FIFO of `fetch_entry_t`, parameter depth, ports push/pop/flush/full/empty/head; flush has priority over push and pop.
- Top holds PC register, FSM, push/redirect logic.

## Test plan
- Reset then `fetch_en`=1, `out_ready`=1, memory words 0..3 = 0x00000013,0x00100093,0x00200113,0x00300193 → outputs in order with `out_pc` 0,4,8,12 on consecutive cycles starting cycle 2.
- `out_ready`=0 for 5 cycles → exactly 2 entries (PC 0,4) queued, `imem_read_en`=0 from cycle 3, `pc`=8 held; release → PC 8 fetched after drain begins, no loss/duplication.
- Redirect to 0x00000023 while queue full and `out_ready`=1 → PC becomes 0x20, head of next valid is PC 0x20 two cycles later, queued PCs never appear.
- `redirect_pc`=0xFFFF_FFFC, run 2 fetches → `out_pc` 0xFFFF_FFFC then 0x0; `imem_addr` 0x3FF then 0x000.
- `rst` asserted mid-stream with `redirect_valid`=1 → next cycle `out_valid`=0, `pc`=RESET_PC, state `IDLE`.
- `fetch_en` toggled 1/0 each cycle, `out_ready`=1 → one instruction every other cycle, PCs contiguous.
